cluster_bbox_extract: RTL and testbench
=======================================

// Module: cluster_bbox_extract
// PURPOSE
//  Upstream stage of the bbox-to-image projection block. Consumes a stream of LiDAR
//  points grouped into clusters (pt_last marks a cluster's final point) and tracks the
//  per-axis signed min/max over each cluster. Emits one axis-aligned 3D bounding box
//  per cluster on a valid/ready port that drives the projection stage's
//  valid_in/ready_out/min_*/max_* inputs directly. Clusters with too few points are dropped.
// PARAMETERS
//  MIN_POINTS  3    clusters with fewer accepted points are discarded (no bbox emitted)
//  CNT_W       12   width of the per-cluster point counter (saturating)
//  DROP_W      16   width of the dropped-cluster counter (saturating)
// PORTS
//  clk          in   1       single clock, all logic on posedge
//  rst_n        in   1       synchronous reset, active-low
//  pt_valid     in   1       point beat valid
//  pt_ready     out  1       point beat accepted when pt_valid & pt_ready
//  pt_last      in   1       beat is the last point of the current cluster
//  pt_x         in   16      signed, s7c8f metres
//  pt_y, pt_z   in   16      signed, s6c9f metres
//  bbox_valid   out  1       bbox output valid; to projection valid_in
//  bbox_ready   in   1       downstream ready; from projection ready_out
//  min_x,max_x  out  16      signed bbox X extent, s7c8f
//  min_y,max_y  out  16      signed bbox Y extent, s6c9f
//  min_z,max_z  out  16      signed bbox Z extent, s6c9f
//  bbox_npts    out  CNT_W   point count of the emitted cluster (saturated)
//  dropped_cnt  out  DROP_W  number of clusters discarded by MIN_POINTS (saturating)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge):
//    - Outputs: all bbox outputs, bbox_npts, dropped_cnt = 0; bbox_valid = 0;
//      pt_ready = 0 while reset is asserted, 1 from the first cycle after.
//    - Internal: state = ACCUM, accumulator empty, first flag = 1.
//    - Reset mid-cluster discards the partial cluster and any pending or held bbox.
//  - Accumulator: regs acc_min/max_{x,y,z} (signed compares), acc_cnt, and a first flag.
//    - On an accepted beat with first=1: min=max=point, cnt=1, first cleared.
//    - Otherwise: per-axis min/max update and cnt+1, saturating at 2^CNT_W-1.
//  - FSM, two states:
//    - ACCUM: pt_ready=1. On an accepted beat with pt_last, the final cluster value
//      (including that beat) is evaluated:
//      - cnt < MIN_POINTS: discard. dropped_cnt+1 (saturating). Accumulator re-armed
//        (first=1). Stay in ACCUM.
//      - cnt >= MIN_POINTS and output register free: load the output register (bbox_valid=1
//        next cycle). Accumulator re-armed. Stay in ACCUM.
//      - cnt >= MIN_POINTS and output register busy: freeze the final value. Go to HOLD.
//    - HOLD: pt_ready=0. When the output register becomes free: load the frozen value,
//      re-arm the accumulator, return to ACCUM.
//  - Output register:
//    - bbox_valid and all bbox data are registered. Data stays stable while bbox_valid=1.
//    - Handshake: bbox_valid & bbox_ready at cycle T. Then bbox_valid=0 at T+1, and data
//      is unchanged through T+1, because projection samples min/max one cycle after its
//      valid_in.
//    - The register is "free" from T+1 onward. There is no same-cycle refill, so the
//      earliest next bbox_valid is T+2.
//  - Latency: pt_last accepted at cycle N with the register free -> bbox_valid=1 at N+1.
//  - A single-beat cluster (pt_last on its first point) is legal: cnt=1, min=max=point.
//  - pt_ready never depends on pt_valid or pt_data; it depends only on FSM state.
// TESTING
//  1. MIN_POINTS=3. Cluster x={0x0100,0xFF00,0x0080}, y={0x0200,0x0000,0xFE00},
//     z={0,0x0040,0xFFC0}, last on the 3rd beat
//     -> 1 cycle later: min_x=FF00, max_x=0100, min_y=FE00, max_y=0200, min_z=FFC0,
//        max_z=0040, npts=3.
//  2. MIN_POINTS=3. 2-point cluster -> no bbox_valid, dropped_cnt=1. A following
//     3-point cluster is emitted normally.
//  3. bbox_ready=0. Two 3-point clusters back-to-back -> after the 2nd last beat,
//     pt_ready=0 (HOLD) and the 1st bbox data is stable. Raise ready at T
//     -> valid=0 and data stable at T+1; 2nd bbox valid at T+2; pt_ready=1 again.
//  4. Signed extremes: points x=0x7FFF, 0x8000, 0x0000 -> min_x=0x8000, max_x=0x7FFF.
//  5. rst_n=0 for 1 cycle after 2 points of a cluster, then a new 3-point cluster
//     -> bbox reflects only the new points; dropped_cnt=0.
//  6. CNT_W=4, MIN_POINTS=3. 20-point cluster -> bbox_npts=15, bbox emitted once.

Source files
------------

// File: rtl/cluster_bbox_extract.sv
// ---------------------------------------------------------------------------
// cluster_bbox_extract
//  Tracks per-axis signed min/max over clusters of LiDAR points and emits one
//  axis-aligned 3D bounding box per cluster toward the projection stage.
//  Clusters with fewer than MIN_POINTS accepted points are dropped and counted.
//
// Ports
//  clk, rst_n           clock, synchronous active-low reset
//  pt_valid/pt_ready    point stream handshake (pt_ready depends on state only)
//  pt_last              final point of the current cluster
//  pt_x                 signed s7c8f metres
//  pt_y, pt_z           signed s6c9f metres
//  bbox_valid/ready     bbox stream handshake (to projection valid_in/ready_out)
//  min_*/max_*          registered bbox extents, stable while bbox_valid=1 and
//                       for one cycle after the accepting handshake
//  bbox_npts            saturated point count of the emitted cluster
//  dropped_cnt          saturating count of clusters discarded by MIN_POINTS
// ---------------------------------------------------------------------------
module cluster_bbox_extract #(
   parameter int unsigned MIN_POINTS = 3,
   parameter int unsigned CNT_W      = 12,
   parameter int unsigned DROP_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pt_valid,
   output logic              pt_ready,
   input  logic              pt_last,
   input  logic [15:0]       pt_x,
   input  logic [15:0]       pt_y,
   input  logic [15:0]       pt_z,
   output logic              bbox_valid,
   input  logic              bbox_ready,
   output logic [15:0]       min_x,
   output logic [15:0]       max_x,
   output logic [15:0]       min_y,
   output logic [15:0]       max_y,
   output logic [15:0]       min_z,
   output logic [15:0]       max_z,
   output logic [CNT_W-1:0]  bbox_npts,
   output logic [DROP_W-1:0] dropped_cnt
);

   localparam int unsigned      DW      = 16;
   localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_POINTS);

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t            state;
   logic              first;
   logic [DW-1:0]     acc_min_x, acc_max_x;
   logic [DW-1:0]     acc_min_y, acc_max_y;
   logic [DW-1:0]     acc_min_z, acc_max_z;
   logic [CNT_W-1:0]  acc_cnt;

   // Cluster value including the beat currently on the input
   logic              beat_acc;
   logic              enough;
   logic [DW-1:0]     fin_min_x, fin_max_x;
   logic [DW-1:0]     fin_min_y, fin_max_y;
   logic [DW-1:0]     fin_min_z, fin_max_z;
   logic [CNT_W-1:0]  fin_cnt;

   function automatic logic [DW-1:0] smin(input logic [DW-1:0] a, input logic [DW-1:0] b);
      return ($signed(a) < $signed(b)) ? a : b;
   endfunction

   function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
      return ($signed(a) > $signed(b)) ? a : b;
   endfunction

   // Fold the incoming point into the running extents
   always_comb begin
      beat_acc  = pt_valid && pt_ready;
      fin_min_x = pt_x;
      fin_max_x = pt_x;
      fin_min_y = pt_y;
      fin_max_y = pt_y;
      fin_min_z = pt_z;
      fin_max_z = pt_z;
      fin_cnt   = CNT_W'(1);
      if (!first) begin
         fin_min_x = smin(acc_min_x, pt_x);
         fin_max_x = smax(acc_max_x, pt_x);
         fin_min_y = smin(acc_min_y, pt_y);
         fin_max_y = smax(acc_max_y, pt_y);
         fin_min_z = smin(acc_min_z, pt_z);
         fin_max_z = smax(acc_max_z, pt_z);
         fin_cnt   = (acc_cnt == {CNT_W{1'b1}}) ? acc_cnt : acc_cnt + CNT_W'(1);
      end
      enough = (fin_cnt >= MIN_CNT);
   end

   // FSM, accumulator and output register.
   // The output register is free only while bbox_valid=0, which keeps data
   // stable through the cycle after a handshake and forbids same-cycle refill.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ACCUM;
         pt_ready    <= 1'b0;
         first       <= 1'b1;
         acc_min_x   <= '0;
         acc_max_x   <= '0;
         acc_min_y   <= '0;
         acc_max_y   <= '0;
         acc_min_z   <= '0;
         acc_max_z   <= '0;
         acc_cnt     <= '0;
         bbox_valid  <= 1'b0;
         min_x       <= '0;
         max_x       <= '0;
         min_y       <= '0;
         max_y       <= '0;
         min_z       <= '0;
         max_z       <= '0;
         bbox_npts   <= '0;
         dropped_cnt <= '0;
      end else begin
         if (bbox_valid && bbox_ready) begin
            bbox_valid <= 1'b0;
         end

         case (state)
            ACCUM: begin
               pt_ready <= 1'b1;
               if (beat_acc) begin
                  if (pt_last && !enough) begin
                     // Too small: discard and re-arm
                     first <= 1'b1;
                     if (dropped_cnt != {DROP_W{1'b1}}) begin
                        dropped_cnt <= dropped_cnt + DROP_W'(1);
                     end
                  end else if (pt_last && !bbox_valid) begin
                     // Output free: publish directly from the folded value
                     first      <= 1'b1;
                     bbox_valid <= 1'b1;
                     min_x      <= fin_min_x;
                     max_x      <= fin_max_x;
                     min_y      <= fin_min_y;
                     max_y      <= fin_max_y;
                     min_z      <= fin_min_z;
                     max_z      <= fin_max_z;
                     bbox_npts  <= fin_cnt;
                  end else begin
                     // Mid-cluster update, or final value frozen until output frees
                     first     <= 1'b0;
                     acc_min_x <= fin_min_x;
                     acc_max_x <= fin_max_x;
                     acc_min_y <= fin_min_y;
                     acc_max_y <= fin_max_y;
                     acc_min_z <= fin_min_z;
                     acc_max_z <= fin_max_z;
                     acc_cnt   <= fin_cnt;
                     if (pt_last) begin
                        state    <= HOLD;
                        pt_ready <= 1'b0;
                     end
                  end
               end
            end

            HOLD: begin
               pt_ready <= 1'b0;
               if (!bbox_valid) begin
                  first      <= 1'b1;
                  bbox_valid <= 1'b1;
                  min_x      <= acc_min_x;
                  max_x      <= acc_max_x;
                  min_y      <= acc_min_y;
                  max_y      <= acc_max_y;
                  min_z      <= acc_min_z;
                  max_z      <= acc_max_z;
                  bbox_npts  <= acc_cnt;
                  state      <= ACCUM;
                  pt_ready   <= 1'b1;
               end
            end

            default: begin
               state    <= ACCUM;
               pt_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cluster_bbox_extract.sv
// Self-checking bench for cluster_bbox_extract: directed vector table,
// hand-written multi-cycle sequences, and a randomized scoreboard phase.
module tb_cluster_bbox_extract;

   typedef struct packed {
      logic [15:0] mnx, mxx, mny, mxy, mnz, mxz;
      logic [11:0] n;
   } bbox_t;

   typedef struct packed {
      logic [3:0]       n;
      logic [3:0][15:0] x, y, z;
      logic             emit;
      bbox_t            exp;
      logic [15:0]      drop;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pt_valid, pt_ready, pt_last;
   logic [15:0] pt_x, pt_y, pt_z;
   logic        bbox_valid, bbox_ready;
   logic [15:0] min_x, max_x, min_y, max_y, min_z, max_z;
   logic [11:0] bbox_npts;
   logic [15:0] dropped_cnt;

   logic        s_pt_valid, s_pt_ready;
   logic        s_bbox_valid, s_bbox_ready;
   logic [15:0] s_min_x, s_max_x, s_min_y, s_max_y, s_min_z, s_max_z;
   logic [3:0]  s_npts;
   logic [15:0] s_dropped;

   int errors = 0;
   int checks = 0;

   bbox_t exp_q[$];
   int    m_drop;
   bit    drv_done, all_done;
   vec_t  vecs[6];

   always #5 clk = ~clk;

   cluster_bbox_extract dut (
      .clk(clk), .rst_n(rst_n),
      .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_last(pt_last),
      .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z),
      .bbox_valid(bbox_valid), .bbox_ready(bbox_ready),
      .min_x(min_x), .max_x(max_x), .min_y(min_y), .max_y(max_y),
      .min_z(min_z), .max_z(max_z),
      .bbox_npts(bbox_npts), .dropped_cnt(dropped_cnt)
   );

   cluster_bbox_extract #(.MIN_POINTS(3), .CNT_W(4), .DROP_W(16)) dut_s (
      .clk(clk), .rst_n(rst_n),
      .pt_valid(s_pt_valid), .pt_ready(s_pt_ready), .pt_last(pt_last),
      .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z),
      .bbox_valid(s_bbox_valid), .bbox_ready(s_bbox_ready),
      .min_x(s_min_x), .max_x(s_max_x), .min_y(s_min_y), .max_y(s_max_y),
      .min_z(s_min_z), .max_z(s_max_z),
      .bbox_npts(s_npts), .dropped_cnt(s_dropped)
   );

   function automatic logic [127:0] cur_bbox();
      return 128'({min_x, max_x, min_y, max_y, min_z, max_z, bbox_npts});
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Caller is at posedge+#1; returns at posedge+#1 just after acceptance
   task automatic send_pt(input bit sel, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] z, input logic last);
      int n;
      n = 0;
      pt_x = x; pt_y = y; pt_z = z; pt_last = last;
      if (sel) s_pt_valid = 1'b1; else pt_valid = 1'b1;
      @(negedge clk);
      while (!(sel ? s_pt_ready : pt_ready) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) chk("pt_ready_timeout", 128'(0), 128'(1));
      sync();
      pt_valid = 1'b0; s_pt_valid = 1'b0; pt_last = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      sync();
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; pt_valid = 1'b0; pt_last = 1'b0;
      pt_x = '0; pt_y = '0; pt_z = '0;
      bbox_ready = 1'b1; s_pt_valid = 1'b0; s_bbox_ready = 1'b1;

      vecs[0] = '{n:4'd3, x:64'h0000_0080_FF00_0100, y:64'h0000_FE00_0000_0200,
                  z:64'h0000_FFC0_0040_0000, emit:1'b1,
                  exp:'{mnx:16'hFF00, mxx:16'h0100, mny:16'hFE00, mxy:16'h0200,
                        mnz:16'hFFC0, mxz:16'h0040, n:12'd3}, drop:16'd0};
      vecs[1] = '{n:4'd2, x:64'h0000_0000_0002_0001, y:64'h0, z:64'h0, emit:1'b0,
                  exp:'0, drop:16'd1};
      vecs[2] = '{n:4'd3, x:64'h0000_0030_0020_0010, y:64'h0000_0000_FFFB_0005,
                  z:64'h0000_1000_1000_1000, emit:1'b1,
                  exp:'{mnx:16'h0010, mxx:16'h0030, mny:16'hFFFB, mxy:16'h0005,
                        mnz:16'h1000, mxz:16'h1000, n:12'd3}, drop:16'd1};
      vecs[3] = '{n:4'd3, x:64'h0000_0000_8000_7FFF, y:64'h0, z:64'h0, emit:1'b1,
                  exp:'{mnx:16'h8000, mxx:16'h7FFF, mny:16'h0, mxy:16'h0,
                        mnz:16'h0, mxz:16'h0, n:12'd3}, drop:16'd1};
      vecs[4] = '{n:4'd1, x:64'h0000_0000_0000_1234, y:64'h0000_0000_0000_0042,
                  z:64'h0000_0000_0000_FFFF, emit:1'b0, exp:'0, drop:16'd2};
      vecs[5] = '{n:4'd4, x:64'h0000_0001_FFFE_FFFF, y:64'h0100_0100_0100_0100,
                  z:64'h0001_0000_7FFF_8000, emit:1'b1,
                  exp:'{mnx:16'hFFFE, mxx:16'h0001, mny:16'h0100, mxy:16'h0100,
                        mnz:16'h8000, mxz:16'h7FFF, n:12'd4}, drop:16'd2};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_pt_ready", 128'(pt_ready), 128'(0));
      chk("rst_bbox_valid", 128'(bbox_valid), 128'(0));
      chk("rst_bbox", cur_bbox(), 128'(0));
      chk("rst_dropped", 128'(dropped_cnt), 128'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      sync();
      @(negedge clk);
      chk("post_rst_pt_ready", 128'(pt_ready), 128'(1));
      sync();

      // Directed vector table, downstream always ready
      foreach (vecs[i]) begin
         for (int p = 0; p < int'(vecs[i].n); p++)
            send_pt(1'b0, vecs[i].x[p], vecs[i].y[p], vecs[i].z[p], p == int'(vecs[i].n) - 1);
         @(negedge clk);
         chk($sformatf("vec%0d_valid", i), 128'(bbox_valid), 128'(vecs[i].emit));
         if (vecs[i].emit) chk($sformatf("vec%0d_bbox", i), cur_bbox(), 128'(vecs[i].exp));
         chk($sformatf("vec%0d_dropped", i), 128'(dropped_cnt), 128'(vecs[i].drop));
         sync();
      end

      // Back-pressure: second cluster parks in HOLD
      do_reset();
      bbox_ready = 1'b0;
      for (int p = 0; p < 3; p++) send_pt(1'b0, vecs[0].x[p], vecs[0].y[p], vecs[0].z[p], p == 2);
      for (int p = 0; p < 3; p++) send_pt(1'b0, vecs[2].x[p], vecs[2].y[p], vecs[2].z[p], p == 2);
      @(negedge clk);
      chk("hold_pt_ready", 128'(pt_ready), 128'(0));
      chk("hold_valid", 128'(bbox_valid), 128'(1));
      chk("hold_bbox_a", cur_bbox(), 128'(vecs[0].exp));
      @(negedge clk);
      chk("hold_bbox_a_stable", cur_bbox(), 128'(vecs[0].exp));
      bbox_ready = 1'b1;
      @(posedge clk); #1;
      bbox_ready = 1'b0;
      @(negedge clk);
      chk("t1_valid", 128'(bbox_valid), 128'(0));
      chk("t1_bbox_stable", cur_bbox(), 128'(vecs[0].exp));
      chk("t1_pt_ready", 128'(pt_ready), 128'(0));
      @(negedge clk);
      chk("t2_valid", 128'(bbox_valid), 128'(1));
      chk("t2_bbox_b", cur_bbox(), 128'(vecs[2].exp));
      chk("t2_pt_ready", 128'(pt_ready), 128'(1));
      bbox_ready = 1'b1;
      sync();

      // Reset mid-cluster discards the partial cluster
      send_pt(1'b0, 16'h7000, 16'h7000, 16'h7000, 1'b0);
      send_pt(1'b0, 16'h9000, 16'h9000, 16'h9000, 1'b0);
      do_reset();
      @(negedge clk);
      chk("midrst_pt_ready", 128'(pt_ready), 128'(0));
      chk("midrst_valid", 128'(bbox_valid), 128'(0));
      sync();
      for (int p = 0; p < 3; p++) send_pt(1'b0, vecs[2].x[p], vecs[2].y[p], vecs[2].z[p], p == 2);
      @(negedge clk);
      chk("midrst_bbox", cur_bbox(), 128'(vecs[2].exp));
      chk("midrst_dropped", 128'(dropped_cnt), 128'(0));
      sync();

      // Counter saturation on the narrow instance
      for (int p = 0; p < 20; p++) send_pt(1'b1, 16'(p), 16'(2 * p), 16'h0, p == 19);
      @(negedge clk);
      chk("sat_valid", 128'(s_bbox_valid), 128'(1));
      chk("sat_npts", 128'(s_npts), 128'(15));
      chk("sat_x", 128'({s_min_x, s_max_x}), 128'({16'h0000, 16'h0013}));
      @(negedge clk);
      chk("sat_once", 128'(s_bbox_valid), 128'(0));
      sync();

      // Randomized clusters against a reference model
      do_reset();
      m_drop = 0; drv_done = 1'b0; all_done = 1'b0;
      fork
         begin : drv
            int n;
            for (int c = 0; c < 40; c++) begin
               int          len;
               logic [15:0] px[$], py[$], pz[$];
               int          mnx, mxx, mny, mxy, mnz, mxz;
               bbox_t       b;
               len = int'($urandom_range(1, 6));
               for (int p = 0; p < len; p++) begin
                  px.push_back(($urandom_range(0, 4) == 0) ? 16'h8000 : 16'($urandom));
                  py.push_back(($urandom_range(0, 4) == 0) ? 16'h7FFF : 16'($urandom));
                  pz.push_back(16'($urandom));
               end
               mnx = 32767; mxx = -32768; mny = 32767; mxy = -32768; mnz = 32767; mxz = -32768;
               for (int p = 0; p < len; p++) begin
                  if (int'($signed(px[p])) < mnx) mnx = int'($signed(px[p]));
                  if (int'($signed(px[p])) > mxx) mxx = int'($signed(px[p]));
                  if (int'($signed(py[p])) < mny) mny = int'($signed(py[p]));
                  if (int'($signed(py[p])) > mxy) mxy = int'($signed(py[p]));
                  if (int'($signed(pz[p])) < mnz) mnz = int'($signed(pz[p]));
                  if (int'($signed(pz[p])) > mxz) mxz = int'($signed(pz[p]));
               end
               if (len >= 3) begin
                  b = '{mnx:16'(mnx), mxx:16'(mxx), mny:16'(mny), mxy:16'(mxy),
                        mnz:16'(mnz), mxz:16'(mxz), n:12'(len)};
                  exp_q.push_back(b);
               end else begin
                  m_drop++;
               end
               for (int p = 0; p < len; p++) begin
                  if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) sync();
                  send_pt(1'b0, px[p], py[p], pz[p], p == len - 1);
               end
            end
            drv_done = 1'b1;
            n = 0;
            while (exp_q.size() != 0 && n < 200) begin
               @(negedge clk);
               n++;
            end
            chk("rand_drain", 128'(exp_q.size()), 128'(0));
            chk("rand_dropped", 128'(dropped_cnt), 128'(m_drop));
            all_done = 1'b1;
         end
         begin : rdy
            while (!drv_done) begin
               sync();
               bbox_ready = ($urandom_range(0, 2) != 0);
            end
            bbox_ready = 1'b1;
         end
         begin : mon
            while (!all_done) begin
               @(negedge clk);
               if (bbox_valid && bbox_ready) begin
                  if (exp_q.size() == 0) chk("rand_extra_bbox", 128'(1), 128'(0));
                  else chk("rand_bbox", cur_bbox(), 128'(exp_q.pop_front()));
               end
            end
         end
      join

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
